// File: rtl/bus_master_if.sv
// Signal bundle for bus_master: requester command channel, AHB-style slave bus and
// completion status. "master" is the view of bus_master, "slave" the view of its environment.
interface bus_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;

    logic [15:0] HADDR;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic        hsel_1;
    logic        hsel_2;
    logic [31:0] HRDATA;
    logic        sl_rdy;
    logic        slrsp;

    logic        done_valid;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] rd_data;
    logic [15:0] txn_count;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, HRDATA, sl_rdy, slrsp,
        output cmd_ready, HADDR, HWDATA, HWRITE, hsel_1, hsel_2,
               done_valid, rsp_err, rsp_timeout, rd_data, txn_count
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, HRDATA, sl_rdy, slrsp,
        input  cmd_ready, HADDR, HWDATA, HWRITE, hsel_1, hsel_2,
               done_valid, rsp_err, rsp_timeout, rd_data, txn_count
    );
endinterface

// File: rtl/bus_master.sv
// Single-outstanding bus master: IDLE -> ADDR -> DATA (wait states) -> DONE, all outputs registered.
// Define MASTER_TIMEOUT_EN to bound the DATA wait with TIMEOUT_CYCLES and report rsp_timeout.
module bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic         clk,
    input  logic         rst,
    bus_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_e;

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
        $error("bus_master: TIMEOUT_CYCLES must lie in 1..255");
    end

    state_e      state_q, state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic [15:0] haddr_q, haddr_d;
    logic        hwrite_q, hwrite_d;
    logic        hsel_1_q, hsel_1_d;
    logic        hsel_2_q, hsel_2_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [31:0] wdata_q, wdata_d;
    logic        done_valid_q, done_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic [15:0] txn_count_q, txn_count_d;
    logic        finish;
`ifdef MASTER_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        rsp_timeout_q, rsp_timeout_d;
`endif

    always_comb begin
        // NOTE: every _d starts from its _q, so no path through this block can infer a latch.
        state_d      = state_q;
        cmd_ready_d  = cmd_ready_q;
        haddr_d      = haddr_q;
        hwrite_d     = hwrite_q;
        hsel_1_d     = hsel_1_q;
        hsel_2_d     = hsel_2_q;
        hwdata_d     = hwdata_q;
        wdata_d      = wdata_q;
        done_valid_d = done_valid_q;
        rsp_err_d    = rsp_err_q;
        rd_data_d    = rd_data_q;
        txn_count_d  = txn_count_q;
        finish       = 1'b0;
`ifdef MASTER_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        rsp_timeout_d = rsp_timeout_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_d     = ADDR;
                    cmd_ready_d = 1'b0;
                    haddr_d     = bus.cmd_addr;
                    hwrite_d    = bus.cmd_write;
                    hsel_1_d    = ~bus.cmd_addr[15];
                    hsel_2_d    = bus.cmd_addr[15];
                    wdata_d     = bus.cmd_wdata;
                end
            end
            ADDR: begin
                state_d  = DATA;
                hwdata_d = hwrite_q ? wdata_q : 32'h0;
`ifdef MASTER_TIMEOUT_EN
                wait_cnt_d = 8'h0;
`endif
            end
            DATA: begin
                // A ready slave wins over a timeout expiring on the same edge.
                if (bus.sl_rdy) begin
                    finish    = 1'b1;
                    rsp_err_d = bus.slrsp;
                    if (!hwrite_q) begin
                        rd_data_d = bus.HRDATA;
                    end
`ifdef MASTER_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
                end else if (wait_cnt_q + 8'd1 == TIMEOUT_LIMIT) begin
                    finish        = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
`endif
                end
                if (finish) begin
                    state_d      = DONE;
                    done_valid_d = 1'b1;
                    txn_count_d  = txn_count_q + 16'd1;
                    haddr_d      = 16'h0;
                    hwrite_d     = 1'b0;
                    hsel_1_d     = 1'b0;
                    hsel_2_d     = 1'b0;
                    hwdata_d     = 32'h0;
                end
            end
            DONE: begin
                state_d      = IDLE;
                done_valid_d = 1'b0;
                cmd_ready_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: every register, including the latched write data, is reset so an abandoned
    // transaction leaves nothing behind; cmd_ready is the only flop that resets to 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cmd_ready_q  <= 1'b1;
            haddr_q      <= 16'h0;
            hwrite_q     <= 1'b0;
            hsel_1_q     <= 1'b0;
            hsel_2_q     <= 1'b0;
            hwdata_q     <= 32'h0;
            wdata_q      <= 32'h0;
            done_valid_q <= 1'b0;
            rsp_err_q    <= 1'b0;
            rd_data_q    <= 32'h0;
            txn_count_q  <= 16'h0;
`ifdef MASTER_TIMEOUT_EN
            wait_cnt_q    <= 8'h0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking updates keep every flop sampling pre-edge values.
            state_q      <= state_d;
            cmd_ready_q  <= cmd_ready_d;
            haddr_q      <= haddr_d;
            hwrite_q     <= hwrite_d;
            hsel_1_q     <= hsel_1_d;
            hsel_2_q     <= hsel_2_d;
            hwdata_q     <= hwdata_d;
            wdata_q      <= wdata_d;
            done_valid_q <= done_valid_d;
            rsp_err_q    <= rsp_err_d;
            rd_data_q    <= rd_data_d;
            txn_count_q  <= txn_count_d;
`ifdef MASTER_TIMEOUT_EN
            wait_cnt_q    <= wait_cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
`endif
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.HADDR      = haddr_q;
    assign bus.HWRITE     = hwrite_q;
    assign bus.hsel_1     = hsel_1_q;
    assign bus.hsel_2     = hsel_2_q;
    assign bus.HWDATA     = hwdata_q;
    assign bus.done_valid = done_valid_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.txn_count  = txn_count_q;
`ifdef MASTER_TIMEOUT_EN
    assign bus.rsp_timeout = rsp_timeout_q;
`else
    assign bus.rsp_timeout = 1'b0;
`endif
endmodule

// File: doc/bus_master.md
BUS_MASTER -- requirements
Module: bus_master

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 15, wait-state limit in DATA before forced error (legal 1..255).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port: cmd_valid  input  1  requester presents a transaction.
REQ-005 SHALL have port: cmd_ready  output  1  master can accept a transaction.
REQ-006 SHALL have port: cmd_write  input  1  1 = write, 0 = read.
REQ-007 SHALL have port: cmd_addr  input  16  target address.
REQ-008 SHALL have port: cmd_wdata  input  32  write data.
REQ-009 SHALL have port: HADDR  output  16  bus address to slaves.
REQ-010 SHALL have port: HWDATA  output  32  bus write data.
REQ-011 SHALL have port: HWRITE  output  1  bus direction.
REQ-012 SHALL have port: hsel_1  output  1  slave 1 select (HADDR[15]=0).
REQ-013 SHALL have port: hsel_2  output  1  slave 2 select (HADDR[15]=1).
REQ-014 SHALL have port: HRDATA  input  32  read data from selected slave.
REQ-015 SHALL have port: sl_rdy  input  1  slave ready, ends data phase.
REQ-016 SHALL have port: slrsp  input  1  slave response, 0 OKAY, 1 ERROR; valid with sl_rdy.
REQ-017 SHALL have port: done_valid  output  1  one-cycle completion pulse.
REQ-018 SHALL have port: rsp_err  output  1  completed transaction failed.
REQ-019 SHALL have port: rsp_timeout  output  1  failure caused by timeout.
REQ-020 SHALL have port: rd_data  output  32  captured read data.
REQ-021 SHALL have port: txn_count  output  16  completed transactions, wraps 0xFFFF->0x0000.

Function
REQ-022 SHALL implement FSM states IDLE, ADDR, DATA, DONE.
REQ-023 SHALL assert cmd_ready only in IDLE; cmd_valid&cmd_ready at an edge latches cmd_* and moves to ADDR.
REQ-024 SHALL in ADDR drive HADDR, HWRITE from latched command and assert exactly one hsel_x per HADDR[15]; always advance to DATA next edge.
REQ-025 SHALL in DATA hold HADDR, HWRITE, hsel_x and drive HWDATA (latched wdata on write, 0 on read).
REQ-026 SHALL in DATA on edge with sl_rdy=1 capture slrsp into rsp_err, HRDATA into rd_data (reads only; writes leave rd_data unchanged), clear rsp_timeout, move to DONE.
REQ-027 SHALL in DONE assert done_valid for exactly one cycle, increment txn_count, return to IDLE; rsp_err/rsp_timeout/rd_data hold until next completion.
REQ-028 SHALL give minimum latency of 3 edges from accept to done_valid (sl_rdy high on first DATA cycle); each low sl_rdy cycle adds one.
REQ-029 SHALL drive hsel_1, hsel_2, HWRITE, HWDATA to 0 and HADDR to 0 in IDLE and DONE.
REQ-030 SHALL ignore sl_rdy, slrsp, HRDATA outside DATA.
REQ-031 SHALL ignore cmd_valid outside IDLE; a new command is accepted no earlier than the cycle after DONE.

Reset
REQ-032 SHALL on rst=0, immediately and regardless of state, enter IDLE and force all outputs and internal registers to 0, except cmd_ready=1.
REQ-033 SHALL on reset during ADDR/DATA abandon the transaction with no done_valid and no txn_count increment.

Configuration
REQ-034 SHALL with MASTER_TIMEOUT_EN defined keep an 8-bit wait counter, cleared on entering DATA, incremented each DATA cycle with sl_rdy=0; when it reaches TIMEOUT_CYCLES with sl_rdy still 0, go to DONE with rsp_err=1, rsp_timeout=1, rd_data unchanged.
REQ-035 SHALL with MASTER_TIMEOUT_EN undefined contain no wait counter, wait in DATA indefinitely, and tie rsp_timeout to 0.
REQ-036 SHALL give sl_rdy=1 priority over timeout when both occur on the same edge.

Verification
REQ-037 SHALL cover: write addr 0x0008 data 20, sl_rdy high immediately -> hsel_1=1, HWDATA=20 in DATA, done_valid 3 edges after accept, rsp_err=0, txn_count=1.
REQ-038 SHALL cover: read addr 0x8004, HRDATA=0xDEADBEEF, sl_rdy after 4 wait cycles -> hsel_2=1, rd_data=0xDEADBEEF, done_valid 7 edges after accept.
REQ-039 SHALL cover: write with slrsp=1 at sl_rdy -> rsp_err=1, rsp_timeout=0, txn_count increments.
REQ-040 SHALL cover (MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=15): sl_rdy held 0 -> done_valid with rsp_err=1, rsp_timeout=1 after 15 DATA cycles; sl_rdy rising on the 15th cycle -> normal completion.
REQ-041 SHALL cover: rst=0 mid-DATA -> outputs zero asynchronously, cmd_ready=1, no done_valid; txn_count preset to 0xFFFF via 65535 transactions then one more -> 0x0000.
